txn_bus_scheduler: RTL
======================

Name: txn_bus_scheduler

Overview:
- Packet-level scheduler for the shared 8-bit data bus between the AES and SHA control FSMs.
- Locks the bus to one requester for a whole transaction (a byte stream terminated by a last flag).
- Alternates ownership round-robin between transactions and drives a registered, back-pressured byte interface onto the bus.
- Releases a stalled owner after a timeout and reports the error, so one hung FSM cannot deadlock the other.

Parameters:
- TIMEOUT, 16, consecutive owner-idle cycles (owner req low mid-transaction) before forced release; must be >= 1.
- TOW, $clog2(TIMEOUT+1), width of the idle counter (localparam, derived).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, active-low, asynchronous
- aes_req  input  1  AES FSM has a byte available on aes_data
- aes_data  input  8  AES byte
- aes_last  input  1  aes_data is the final byte of the AES transaction
- aes_grant  output  1  combinational; AES byte accepted this cycle, AES FSM advances
- sha_req  input  1  SHA FSM has a byte available on sha_data
- sha_data  input  8  SHA byte
- sha_last  input  1  sha_data is the final byte of the SHA transaction
- sha_grant  output  1  combinational; SHA byte accepted this cycle
- bus_ready  input  1  bus consumes data_out this cycle when valid_out=1
- data_out  output  8  registered bus byte
- valid_out  output  1  registered; data_out valid
- bus_owner  output  2  registered; 00 none, 01 AES, 10 SHA
- timeout_err  output  1  registered one-cycle pulse on forced release

Behaviour:
- Reset values (async, rst_n low): state=IDLE, data_out=0, valid_out=0, bus_owner=00, timeout_err=0, idle_cnt=0, last_served=SHA (AES wins first tie).
- States and transitions:
  - IDLE: no grants. If exactly one req is high, go to that owner's burst state. If both are high, go to the requester that is not last_served. bus_owner updates on the same edge.
  - AES_BURST / SHA_BURST: owner's byte is accepted when owner req=1 and slot_free, where slot_free = !valid_out || bus_ready.
  - On accept: grant=1 for that cycle; data_out<=owner data and valid_out<=1 at the next edge.
  - Non-owner grant is always 0.
  - On accept with last=1: go to IDLE at the next edge, last_served<=owner, bus_owner<=00.
  - Bubble between transactions is exactly one IDLE cycle.
- Bus side:
  - A byte transfers on a cycle with valid_out=1 and bus_ready=1.
  - If no new accept happens that cycle, valid_out<=0.
  - data_out is held stable while valid_out=1 and bus_ready=0.
  - Back-to-back accepts sustain 1 byte/cycle while bus_ready=1.
- Latency: req asserted in IDLE at cycle 0 → grant at cycle 1 (if slot free) → byte on data_out/valid_out at cycle 2.
- Timeout:
  - In a burst state, idle_cnt increments each cycle the owner req=0 and clears whenever owner req=1.
  - When idle_cnt reaches TIMEOUT: go to IDLE, last_served<=owner, bus_owner<=00, timeout_err=1 for one cycle, idle_cnt<=0.
  - A byte already in the output register still completes normally.
- Boundaries:
  - bus_ready=0 does not count as owner-idle.
  - last accepted on the same cycle a timeout would fire: last wins, no timeout_err.
  - Both reqs rise together repeatedly: strict alternation AES, SHA, AES, ...
  - rst_n assertion mid-burst: immediate return to reset values; the partial transaction is dropped.

Optional Feature:
- Macro SCHED_SHA_PRIO_EN.
- Defined: fixed priority; on a tie in IDLE, SHA always wins and last_served is ignored. Transaction locking and timeout are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single AES transaction, 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), bus_ready=1 → aes_grant at cycles 1–3; data_out A1/A2/A3 at cycles 2–4; bus_owner=01 during the burst, 00 after.
- Simultaneous req from reset, 2-byte transactions each (AES 0x11, 0x12; SHA 0x21, 0x22) → bus order 11, 12, 21, 22; exactly one IDLE cycle between transactions; with SCHED_SHA_PRIO_EN: 21, 22, 11, 12.
- Back-pressure: bus_ready low for 4 cycles mid-AES-burst → data_out held; aes_grant=0 while the slot is full; no byte lost or duplicated; no timeout_err.
- SHA drops req after 1 byte; TIMEOUT=16, AES waiting → timeout_err pulses once after 16 idle cycles; AES granted 2 cycles later.
- Owner req drops for 15 cycles, then resumes → no timeout; idle_cnt resets; transaction completes.
- rst_n pulsed low mid-SHA-burst → all outputs 0 asynchronously; after release, AES wins the first tie.

Source files
------------

// File: rtl/txn_bus_scheduler.sv
// Transaction-locked scheduler for the byte bus shared by the AES and SHA FSMs.
// Define SCHED_SHA_PRIO_EN to make SHA win every tie in IDLE instead of using round-robin.
module txn_bus_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aes_req,
    input  logic [7:0] aes_data,
    input  logic       aes_last,
    output logic       aes_grant,
    input  logic       sha_req,
    input  logic [7:0] sha_data,
    input  logic       sha_last,
    output logic       sha_grant,
    input  logic       bus_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] bus_owner,
    output logic       timeout_err
);

    localparam int TOW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_AES  = 2'b01;
    localparam logic [1:0] OWN_SHA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AES  = 2'b01,
        ST_SHA  = 2'b10
    } state_t;

    state_t           state_r;
    logic [7:0]       data_out_r;
    logic             valid_out_r;
    logic [1:0]       bus_owner_r;
    logic             timeout_err_r;
    logic [TOW-1:0]   idle_cnt_r;
    logic             last_served_r;   // 1 = SHA was served last

    logic             slot_free_s;
    logic             owner_req_s;
    logic [7:0]       owner_data_s;
    logic             owner_last_s;
    logic             accept_s;
    logic [TOW-1:0]   idle_next_s;
    logic             timeout_hit_s;
    logic             pick_sha_s;

    // Select the current owner's request lane and decide accept / timeout
    always_comb begin
        slot_free_s  = !valid_out_r || bus_ready;
        owner_req_s  = 1'b0;
        owner_data_s = 8'h00;
        owner_last_s = 1'b0;
        case (state_r)
            ST_AES: begin
                owner_req_s  = aes_req;
                owner_data_s = aes_data;
                owner_last_s = aes_last;
            end
            ST_SHA: begin
                owner_req_s  = sha_req;
                owner_data_s = sha_data;
                owner_last_s = sha_last;
            end
            default: begin
                owner_req_s  = 1'b0;
                owner_data_s = 8'h00;
                owner_last_s = 1'b0;
            end
        endcase
        accept_s      = (state_r != ST_IDLE) && owner_req_s && slot_free_s;
        idle_next_s   = idle_cnt_r + TOW'(1);
        // Fires on the idle cycle that would bring the count up to TIMEOUT, so an
        // accept (which needs req=1) can never coincide with a forced release.
        timeout_hit_s = (state_r != ST_IDLE) && !owner_req_s && (idle_next_s == TOW'(TIMEOUT));
    end

    // Arbitration among requests seen in IDLE
    always_comb begin
        pick_sha_s = 1'b0;
`ifdef SCHED_SHA_PRIO_EN
        if (sha_req) begin
            pick_sha_s = 1'b1;
        end else begin
            pick_sha_s = 1'b0;
        end
`else
        if (aes_req && sha_req) begin
            pick_sha_s = !last_served_r;
        end else begin
            pick_sha_s = sha_req;
        end
`endif
    end

    // Grants are combinational so the FSMs advance in the same cycle as the accept
    always_comb begin
        aes_grant = 1'b0;
        sha_grant = 1'b0;
        if (accept_s) begin
            aes_grant = (state_r == ST_AES);
            sha_grant = (state_r == ST_SHA);
        end else begin
            aes_grant = 1'b0;
            sha_grant = 1'b0;
        end
    end

    // Scheduler FSM with output register, idle counter and round-robin memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            data_out_r    <= 8'h00;
            valid_out_r   <= 1'b0;
            bus_owner_r   <= OWN_NONE;
            timeout_err_r <= 1'b0;
            idle_cnt_r    <= '0;
            last_served_r <= 1'b1;
        end else begin
            timeout_err_r <= 1'b0;

            if (accept_s) begin
                data_out_r  <= owner_data_s;
                valid_out_r <= 1'b1;
            end else if (bus_ready) begin
                valid_out_r <= 1'b0;
            end else begin
                valid_out_r <= valid_out_r;
            end

            case (state_r)
                ST_IDLE: begin
                    idle_cnt_r <= '0;
                    if (pick_sha_s) begin
                        state_r     <= ST_SHA;
                        bus_owner_r <= OWN_SHA;
                    end else if (aes_req) begin
                        state_r     <= ST_AES;
                        bus_owner_r <= OWN_AES;
                    end else begin
                        state_r     <= ST_IDLE;
                        bus_owner_r <= OWN_NONE;
                    end
                end
                ST_AES, ST_SHA: begin
                    if (accept_s && owner_last_s) begin
                        state_r       <= ST_IDLE;
                        bus_owner_r   <= OWN_NONE;
                        last_served_r <= (state_r == ST_SHA);
                        idle_cnt_r    <= '0;
                    end else if (timeout_hit_s) begin
                        state_r       <= ST_IDLE;
                        bus_owner_r   <= OWN_NONE;
                        last_served_r <= (state_r == ST_SHA);
                        timeout_err_r <= 1'b1;
                        idle_cnt_r    <= '0;
                    end else if (owner_req_s) begin
                        // a stalled bus (bus_ready=0) is not owner idleness
                        idle_cnt_r <= '0;
                    end else begin
                        idle_cnt_r <= idle_next_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bus_owner_r <= OWN_NONE;
                    idle_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign data_out    = data_out_r;
    assign valid_out   = valid_out_r;
    assign bus_owner   = bus_owner_r;
    assign timeout_err = timeout_err_r;

endmodule
